// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : matrix_pkg
//  Purpose   : Shared constants and state encodings for the matrix printers:
//              ASCII codes, matrix geometry and FSM state types.
//  Revision  : 1.0  initial release
// ============================================================================
package matrix_pkg;

    // Matrix geometry shared by parser/printer blocks
    localparam int MATRIX_MAX_DIM   = 5;
    localparam int MATRIX_ELEM_W    = 8;
    localparam int MATRIX_FLAT_W    = MATRIX_MAX_DIM * MATRIX_MAX_DIM * MATRIX_ELEM_W;

    // ASCII codes used on the terminal link
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_X     = 8'h78;

    // Printer sequencing states
    typedef enum logic [2:0] {
        PRN_IDLE    = 3'd0,
        PRN_CONV    = 3'd1,
        PRN_EMIT    = 3'd2,
        PRN_WAIT_HI = 3'd3,
        PRN_WAIT_LO = 3'd4,
        PRN_NEXT    = 3'd5,
        PRN_DONE    = 3'd6,
        PRN_ERR     = 3'd7
    } prn_state_t;

    // Binary-to-decimal converter states
    typedef enum logic [1:0] {
        B2D_IDLE  = 2'd0,
        B2D_HUND  = 2'd1,
        B2D_TENS  = 2'd2,
        B2D_VALID = 2'd3
    } b2d_state_t;

endpackage : matrix_pkg
`default_nettype wire

// File: rtl/matrix_uart_printer_bin2dec_u8.sv
`default_nettype none
// ============================================================================
//  Module    : bin2dec_u8
//  Purpose   : Sequential 8-bit unsigned to hundreds/tens/ones conversion.
//              start latches the value; valid pulses 3 cycles later with the
//              digits and the number of significant digits (1..3).
//  Revision  : 1.0  initial release
// ============================================================================
module bin2dec_u8
    import matrix_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] value,
    output logic       valid,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [1:0] num_digits
);

    b2d_state_t state, state_nxt;
    logic [7:0] rem;
    logic [3:0] hund_q;
    logic [3:0] tens_q;
    logic [3:0] ones_q;
    logic [3:0] tens_div;
    logic [3:0] ones_div;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= B2D_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: one cycle per decimal position, then a one-cycle valid
    always_comb begin
        state_nxt = state;
        case (state)
            B2D_IDLE:  if (start) state_nxt = B2D_HUND;
            B2D_HUND:  state_nxt = B2D_TENS;
            B2D_TENS:  state_nxt = B2D_VALID;
            B2D_VALID: state_nxt = B2D_IDLE;
            default:   state_nxt = B2D_IDLE;
        endcase
    end

    // Largest multiple of ten not exceeding the remainder (remainder < 100 here)
    always_comb begin
        tens_div = 4'd0;
        for (int k = 1; k < 10; k++) begin
            if (rem >= 8'(k * 10)) begin
                tens_div = 4'(k);
            end
        end
        ones_div = 4'(rem - (8'(tens_div) * 8'd10));
    end

    // Digit datapath: subtract hundreds first, then split tens and ones
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem    <= 8'd0;
            hund_q <= 4'd0;
            tens_q <= 4'd0;
            ones_q <= 4'd0;
        end else begin
            case (state)
                B2D_IDLE: begin
                    if (start) begin
                        rem <= value;
                    end
                end
                B2D_HUND: begin
                    if (rem >= 8'd200) begin
                        hund_q <= 4'd2;
                        rem    <= rem - 8'd200;
                    end else if (rem >= 8'd100) begin
                        hund_q <= 4'd1;
                        rem    <= rem - 8'd100;
                    end else begin
                        hund_q <= 4'd0;
                    end
                end
                B2D_TENS: begin
                    tens_q <= tens_div;
                    ones_q <= ones_div;
                end
                default: ;
            endcase
        end
    end

    assign valid      = (state == B2D_VALID);
    assign hundreds   = hund_q;
    assign tens       = tens_q;
    assign ones       = ones_q;
    assign num_digits = (hund_q != 4'd0) ? 2'd3 :
                        (tens_q != 4'd0) ? 2'd2 : 2'd1;

endmodule : bin2dec_u8
`default_nettype wire

// File: rtl/matrix_uart_printer.sv
`default_nettype none
// ============================================================================
//  Module    : matrix_uart_printer
//  Purpose   : Serialises a stored matrix (up to 5x5, 8-bit elements) to
//              ASCII text, one row per line, and feeds uart_tx one byte at a
//              time over its en/busy handshake.
//  Config    : MATRIX_PRINT_HEADER_EN - prefix the output with "<m>x<n>\r\n".
//  Revision  : 1.0  initial release
// ============================================================================
module matrix_uart_printer
    import matrix_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int MAX_DIM   = 5
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [MAX_DIM*MAX_DIM*DATAWIDTH-1:0]  matrix_flat,
    input  logic [2:0]                            m,
    input  logic [2:0]                            n,
    input  logic                                  uart_tx_busy,
    output logic                                  uart_tx_en,
    output logic [7:0]                            uart_tx_data,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  error
);

    localparam int FLAT_W = MAX_DIM * MAX_DIM * DATAWIDTH;

    prn_state_t state, state_nxt;

    // Latched job
    logic [FLAT_W-1:0] mat_q;
    logic [2:0]        m_q;
    logic [2:0]        n_q;
    logic [2:0]        row;
    logic [2:0]        col;
    logic [4:0]        idx;

    // Byte sequence for the current element (digits + separator/line end)
    logic [39:0]       seq_bytes;
    logic [2:0]        byte_idx;
    logic [2:0]        byte_cnt;
    logic [1:0]        hi_cnt;
    logic              conv_req;
`ifdef MATRIX_PRINT_HEADER_EN
    logic              hdr;
`endif

    // Control strobes from the FSM into the datapath
    logic              accept;
    logic              conv_start;
    logic              fill;
    logic              bump_byte;
    logic              step;

    // Converter interface
    logic [7:0]        elem;
    logic              b2d_valid;
    logic [3:0]        b2d_h;
    logic [3:0]        b2d_t;
    logic [3:0]        b2d_o;
    logic [1:0]        b2d_nd;

    logic              dims_ok;
    logic              last_col;
    logic              last_elem;
    logic [7:0]        cur_byte;
    logic [7:0]        ch_h;
    logic [7:0]        ch_t;
    logic [7:0]        ch_o;
    logic [23:0]       dig_vec;
    logic [2:0]        dig_n;
    logic [15:0]       term_vec;
    logic [2:0]        term_n;
    logic [39:0]       elem_bytes;
    logic [2:0]        elem_cnt;

    assign dims_ok   = (m != 3'd0) && (m <= 3'(MAX_DIM)) &&
                       (n != 3'd0) && (n <= 3'(MAX_DIM));
    assign last_col  = (col == n_q - 3'd1);
    assign last_elem = last_col && (row == m_q - 3'd1);
    assign elem      = mat_q[{idx, 3'b000} +: 8];
    assign cur_byte  = seq_bytes[{byte_idx, 3'b000} +: 8];

    bin2dec_u8 u_bin2dec (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (conv_start),
        .value      (elem),
        .valid      (b2d_valid),
        .hundreds   (b2d_h),
        .tens       (b2d_t),
        .ones       (b2d_o),
        .num_digits (b2d_nd)
    );

    // Assemble the element's text: significant digits first, then a space or CR LF
    always_comb begin
        ch_h = ASCII_ZERO + {4'd0, b2d_h};
        ch_t = ASCII_ZERO + {4'd0, b2d_t};
        ch_o = ASCII_ZERO + {4'd0, b2d_o};
        case (b2d_nd)
            2'd3: begin
                dig_vec = {ch_o, ch_t, ch_h};
                dig_n   = 3'd3;
            end
            2'd2: begin
                dig_vec = {8'h00, ch_o, ch_t};
                dig_n   = 3'd2;
            end
            default: begin
                dig_vec = {16'h0000, ch_o};
                dig_n   = 3'd1;
            end
        endcase
        if (last_col) begin
            term_vec = {ASCII_LF, ASCII_CR};
            term_n   = 3'd2;
        end else begin
            term_vec = {8'h00, ASCII_SPACE};
            term_n   = 3'd1;
        end
        elem_bytes = {16'h0000, dig_vec} | ({24'h000000, term_vec} << {dig_n, 3'b000});
        elem_cnt   = dig_n + term_n;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= PRN_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_nxt    = state;
        uart_tx_en   = 1'b0;
        uart_tx_data = 8'h00;
        busy         = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        accept       = 1'b0;
        conv_start   = 1'b0;
        fill         = 1'b0;
        bump_byte    = 1'b0;
        step         = 1'b0;
        case (state)
            PRN_IDLE: begin
                if (start) begin
                    if (dims_ok) begin
                        accept    = 1'b1;
`ifdef MATRIX_PRINT_HEADER_EN
                        state_nxt = PRN_EMIT;
`else
                        state_nxt = PRN_CONV;
`endif
                    end else begin
                        state_nxt = PRN_ERR;
                    end
                end
            end
            PRN_ERR: begin
                error     = 1'b1;
                state_nxt = PRN_IDLE;
            end
            PRN_CONV: begin
                busy       = 1'b1;
                conv_start = !conv_req;
                if (b2d_valid) begin
                    fill      = 1'b1;
                    state_nxt = PRN_EMIT;
                end
            end
            PRN_EMIT: begin
                busy         = 1'b1;
                uart_tx_data = cur_byte;
                if (!uart_tx_busy) begin
                    uart_tx_en = 1'b1;
                    state_nxt  = PRN_WAIT_HI;
                end
            end
            PRN_WAIT_HI: begin
                busy         = 1'b1;
                uart_tx_data = cur_byte;
                // A UART that never raises busy is treated as having taken the byte
                if (uart_tx_busy || (hi_cnt == 2'd3)) begin
                    state_nxt = PRN_WAIT_LO;
                end
            end
            PRN_WAIT_LO: begin
                busy         = 1'b1;
                uart_tx_data = cur_byte;
                if (!uart_tx_busy) begin
                    if (byte_idx == byte_cnt - 3'd1) begin
                        state_nxt = PRN_NEXT;
                    end else begin
                        bump_byte = 1'b1;
                        state_nxt = PRN_EMIT;
                    end
                end
            end
            PRN_NEXT: begin
                busy = 1'b1;
                step = 1'b1;
`ifdef MATRIX_PRINT_HEADER_EN
                if (hdr) begin
                    state_nxt = PRN_CONV;
                end else
`endif
                if (last_elem) begin
                    state_nxt = PRN_DONE;
                end else begin
                    state_nxt = PRN_CONV;
                end
            end
            PRN_DONE: begin
                done      = 1'b1;
                state_nxt = PRN_IDLE;
            end
            default: state_nxt = PRN_IDLE;
        endcase
    end

    // Job latches, position counters and byte sequencing
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mat_q     <= '0;
            m_q       <= 3'd0;
            n_q       <= 3'd0;
            row       <= 3'd0;
            col       <= 3'd0;
            idx       <= 5'd0;
            seq_bytes <= 40'd0;
            byte_idx  <= 3'd0;
            byte_cnt  <= 3'd0;
            hi_cnt    <= 2'd0;
            conv_req  <= 1'b0;
`ifdef MATRIX_PRINT_HEADER_EN
            hdr       <= 1'b0;
`endif
        end else begin
            if (accept) begin
                mat_q    <= matrix_flat;
                m_q      <= m;
                n_q      <= n;
                row      <= 3'd0;
                col      <= 3'd0;
                idx      <= 5'd0;
                byte_idx <= 3'd0;
`ifdef MATRIX_PRINT_HEADER_EN
                seq_bytes <= {ASCII_LF, ASCII_CR, ASCII_ZERO + {5'd0, n},
                              ASCII_X, ASCII_ZERO + {5'd0, m}};
                byte_cnt  <= 3'd5;
                hdr       <= 1'b1;
`endif
            end
            if (conv_start) begin
                conv_req <= 1'b1;
            end
            if (fill) begin
                conv_req  <= 1'b0;
                seq_bytes <= elem_bytes;
                byte_cnt  <= elem_cnt;
                byte_idx  <= 3'd0;
            end
            if (state == PRN_EMIT) begin
                hi_cnt <= 2'd0;
            end else if (state == PRN_WAIT_HI) begin
                hi_cnt <= hi_cnt + 2'd1;
            end
            if (bump_byte) begin
                byte_idx <= byte_idx + 3'd1;
            end
            if (step) begin
`ifdef MATRIX_PRINT_HEADER_EN
                if (hdr) begin
                    hdr <= 1'b0;
                end else
`endif
                begin
                    idx <= idx + 5'd1;
                    if (last_col) begin
                        col <= 3'd0;
                        row <= row + 3'd1;
                    end else begin
                        col <= col + 3'd1;
                    end
                end
            end
        end
    end

endmodule : matrix_uart_printer
`default_nettype wire

// File: tb/tb_matrix_uart_printer.sv
`default_nettype none
// ============================================================================
//  Module    : tb_matrix_uart_printer
//  Purpose   : Directed self-checking bench for matrix_uart_printer with a
//              simple uart_tx busy model and byte capture.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_matrix_uart_printer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [199:0] matrix_flat;
    logic [2:0]   m;
    logic [2:0]   n;
    logic         uart_tx_busy;
    logic         uart_tx_en;
    logic [7:0]   uart_tx_data;
    logic         busy;
    logic         done;
    logic         error;

    int checks   = 0;
    int failures = 0;

    // UART model and monitors
    logic       model_on = 1'b1;
    int         busy_cnt = 0;
    logic [7:0] cap[$];
    int         done_cnt = 0;
    int         err_cnt  = 0;
    int         en_cnt   = 0;
    int         viol_cnt = 0;
    int         busy_hi  = 0;

    always #5 clk = ~clk;

    matrix_uart_printer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .matrix_flat  (matrix_flat),
        .m            (m),
        .n            (n),
        .uart_tx_busy (uart_tx_busy),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_data (uart_tx_data),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    assign uart_tx_busy = model_on && (busy_cnt != 0);

    // uart_tx stand-in: busy for 10 cycles after each strobe; records every byte
    always @(posedge clk) begin
        if (uart_tx_en) begin
            cap.push_back(uart_tx_data);
            en_cnt <= en_cnt + 1;
            if (uart_tx_busy) viol_cnt <= viol_cnt + 1;
            if (model_on) busy_cnt <= 10;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        if (done)  done_cnt <= done_cnt + 1;
        if (error) err_cnt  <= err_cnt + 1;
        if (busy)  busy_hi  <= busy_hi + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic string hdr_str(input int rows, input int cols);
`ifdef MATRIX_PRINT_HEADER_EN
        return $sformatf("%0dx%0d\r\n", rows, cols);
`else
        if (rows < 0 || cols < 0) return "?";
        return "";
`endif
    endfunction

    task automatic set_elem(input int i, input logic [7:0] v);
        matrix_flat[8*i +: 8] = v;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
                check({tag, "_line_idle_at_done"}, {31'd0, uart_tx_busy}, 32'd0);
            end
        end
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        @(negedge clk);
    endtask

    task automatic check_bytes(input string tag, input string exp, input int base);
        int got_n;
        got_n = cap.size() - base;
        check({tag, "_byte_count"}, got_n, exp.len());
        for (int i = 0; i < exp.len() && i < got_n; i++) begin
            checks++;
            assert (cap[base + i] === exp[i]) else begin
                failures++;
                $error("FAIL %s_byte%0d observed=%0h expected=%0h", tag, i, cap[base + i], exp[i]);
                break;
            end
        end
    endtask

    task automatic run_print(input string tag, input string exp, input int budget);
        int base;
        int d0;
        base = cap.size();
        d0   = done_cnt;
        pulse_start();
        check({tag, "_busy_after_start"}, {31'd0, busy}, 32'd1);
        wait_done(tag, budget);
        check_bytes(tag, exp, base);
        check({tag, "_done_pulses"}, done_cnt - d0, 32'd1);
        check({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run_bad(input string tag, input logic [2:0] mm, input logic [2:0] nn);
        int e0;
        int b0;
        e0 = en_cnt;
        b0 = busy_hi;
        m  = mm;
        n  = nn;
        pulse_start();
        check({tag, "_error_pulse"}, {31'd0, error}, 32'd1);
        check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        check({tag, "_error_one_cycle"}, {31'd0, error}, 32'd0);
        repeat (10) @(negedge clk);
        check({tag, "_no_bytes"}, en_cnt - e0, 32'd0);
        check({tag, "_busy_never_high"}, busy_hi - b0, 32'd0);
    endtask

    initial begin
        int base;
        int d0;
        int e0;
        bit reached;
        rst_n       = 1'b0;
        start       = 1'b0;
        matrix_flat = '0;
        m           = 3'd0;
        n           = 3'd0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {20'd0, uart_tx_en, uart_tx_data, busy, done, error}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 2x2 [1,2;3,4]
        m = 3'd2; n = 3'd2;
        set_elem(0, 8'd1); set_elem(1, 8'd2); set_elem(2, 8'd3); set_elem(3, 8'd4);
        run_print("t1_2x2", {hdr_str(2, 2), "1 2\r\n3 4\r\n"}, 3000);

        // 1x3 [0,100,255]
        m = 3'd1; n = 3'd3;
        set_elem(0, 8'd0); set_elem(1, 8'd100); set_elem(2, 8'd255);
        run_print("t2_1x3", {hdr_str(1, 3), "0 100 255\r\n"}, 3000);

        // Bad dimensions
        run_bad("t3_m0", 3'd0, 3'd3);
        run_bad("t3_m6", 3'd6, 3'd1);

        // Restart attempt mid-print with different inputs must not disturb output
        m = 3'd2; n = 3'd2;
        set_elem(0, 8'd5); set_elem(1, 8'd6); set_elem(2, 8'd7); set_elem(3, 8'd8);
        base = cap.size();
        d0   = done_cnt;
        pulse_start();
        repeat (30) @(negedge clk);
        matrix_flat = {200{1'b1}};
        m = 3'd5; n = 3'd5;
        pulse_start();
        wait_done("t4a_restart", 3000);
        check_bytes("t4a_restart", {hdr_str(2, 2), "5 6\r\n7 8\r\n"}, base);
        check("t4a_done_pulses", done_cnt - d0, 32'd1);

        // UART that never raises busy: timeout path
        model_on = 1'b0;
        m = 3'd2; n = 3'd3;
        set_elem(0, 8'd1); set_elem(1, 8'd22); set_elem(2, 8'd3);
        set_elem(3, 8'd44); set_elem(4, 8'd5); set_elem(5, 8'd66);
        run_print("t4b_nobusy", {hdr_str(2, 3), "1 22 3\r\n44 5 66\r\n"}, 3000);
        model_on = 1'b1;
        check("t4_no_strobe_while_busy", viol_cnt, 32'd0);

        // Reset during the third byte of a 5x5 print, then a full reprint
        m = 3'd5; n = 3'd5;
        for (int i = 0; i < 25; i++) set_elem(i, 8'(i * 10));
        base = cap.size();
        d0   = done_cnt;
        e0   = err_cnt;
        pulse_start();
        reached = 0;
        for (int k = 0; k < 2000 && !reached; k++) begin
            @(negedge clk);
            if (cap.size() - base >= 3) reached = 1;
        end
        check("t5_third_byte_reached", {31'd0, reached}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_outputs_after_reset", {20'd0, uart_tx_en, uart_tx_data, busy, done, error}, 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t5_no_done_after_abort", done_cnt - d0, 32'd0);
        check("t5_no_error_after_abort", err_cnt - e0, 32'd0);
        run_print("t5_5x5", {hdr_str(5, 5),
                  "0 10 20 30 40\r\n50 60 70 80 90\r\n100 110 120 130 140\r\n",
                  "150 160 170 180 190\r\n200 210 220 230 240\r\n"}, 5000);

        // 3x4 all nines
        m = 3'd3; n = 3'd4;
        for (int i = 0; i < 12; i++) set_elem(i, 8'd9);
        run_print("t6_3x4", {hdr_str(3, 4), "9 9 9 9\r\n9 9 9 9\r\n9 9 9 9\r\n"}, 4000);
        check("t6_no_strobe_while_busy", viol_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_matrix_uart_printer
`default_nettype wire
